// File: rtl/dht11_sensor_emulator.sv
// rtl/dht11_sensor_emulator.sv - DHT11 sensor emulator answering host start pulses on an open-drain wire
module dht11_sensor_emulator #(
    parameter int TICKS_PER_US = 50,
    parameter int START_MIN_US = 18000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       force_bad_checksum,
    inout  wire        transmission_line,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_count
);
    localparam int TW     = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int US_MAX = (START_MIN_US > 80) ? START_MIN_US : 80;
    localparam int US_W   = $clog2(US_MAX + 1);

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_US - 1);
    localparam logic [US_W-1:0] START_MIN = US_W'(START_MIN_US);
    localparam logic [US_W-1:0] TURN_LAST = US_W'(30 - 1);
    localparam logic [US_W-1:0] RESP_LAST = US_W'(80 - 1);
    localparam logic [US_W-1:0] LOW_LAST  = US_W'(50 - 1);
    localparam logic [US_W-1:0] ZERO_LAST = US_W'(26 - 1);
    localparam logic [US_W-1:0] ONE_LAST  = US_W'(70 - 1);
    localparam logic [5:0]      LAST_BIT  = 6'd39;

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_RELEASE,
        TURNAROUND,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    state_t state, state_next;

    logic            line_meta, line_sync, line_prev;
    logic            line_fall, line_rise;
    logic [TW-1:0]   tick_cnt;
    logic            us_tick;
    logic [US_W-1:0] us_cnt, us_cnt_inc;
    logic            timer_clear;
    logic [39:0]     shreg;
    logic [5:0]      bit_cnt;
    logic [7:0]      sum, checksum;
    logic            drive_low;

    assign transmission_line = drive_low ? 1'b0 : 1'bz;

    assign line_fall = line_prev & ~line_sync;
    assign line_rise = ~line_prev & line_sync;
    assign drive_low = (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);
    assign busy      = (state != IDLE) && (state != START_LOW);
    assign sum       = hum_int + hum_dec + temp_int + temp_dec;
    assign checksum  = force_bad_checksum ? ~sum : sum;

    // Only the start-low measurement can reach START_MIN; it saturates there.
    always_comb begin
        us_tick    = (tick_cnt == TICK_LAST);
        us_cnt_inc = us_cnt;
        if (us_tick && !((state == START_LOW) && (us_cnt == START_MIN)))
            us_cnt_inc = us_cnt + US_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (line_fall && enable)
                    state_next = START_LOW;
            START_LOW:
                if (line_rise)
                    state_next = (us_cnt_inc >= START_MIN) ? WAIT_RELEASE : IDLE;
            WAIT_RELEASE:
                state_next = TURNAROUND;
            TURNAROUND:
                if (us_tick && (us_cnt == TURN_LAST))
                    state_next = RESP_LOW;
            RESP_LOW:
                if (us_tick && (us_cnt == RESP_LAST))
                    state_next = RESP_HIGH;
            RESP_HIGH:
                if (us_tick && (us_cnt == RESP_LAST))
                    state_next = BIT_LOW;
            BIT_LOW:
                if (us_tick && (us_cnt == LOW_LAST))
                    state_next = BIT_HIGH;
            BIT_HIGH:
                if (us_tick && (us_cnt == (shreg[39] ? ONE_LAST : ZERO_LAST)))
                    state_next = (bit_cnt == LAST_BIT) ? END_LOW : BIT_LOW;
            END_LOW:
                if (us_tick && (us_cnt == LOW_LAST))
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    // WAIT_RELEASE is a one-cycle latch slot; its time counts toward the 30 us turnaround.
    assign timer_clear = (state == IDLE) ||
                         ((state_next != state) && (state != WAIT_RELEASE));

    always_ff @(posedge clock) begin
        if (reset) begin
            line_meta   <= 1'b1;
            line_sync   <= 1'b1;
            line_prev   <= 1'b1;
            tick_cnt    <= '0;
            us_cnt      <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            line_meta  <= transmission_line;
            line_sync  <= line_meta;
            line_prev  <= line_sync;
            frame_done <= 1'b0;

            if (timer_clear) begin
                tick_cnt <= '0;
                us_cnt   <= '0;
            end else begin
                tick_cnt <= us_tick ? '0 : tick_cnt + TW'(1);
                us_cnt   <= us_cnt_inc;
            end

            if ((state == START_LOW) && (state_next == WAIT_RELEASE)) begin
                shreg   <= {hum_int, hum_dec, temp_int, temp_dec, checksum};
                bit_cnt <= '0;
            end else if ((state == BIT_HIGH) && (state_next == BIT_LOW)) begin
                shreg   <= {shreg[38:0], 1'b0};
                bit_cnt <= bit_cnt + 6'd1;
            end

            if ((state == END_LOW) && (state_next == IDLE)) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end
        end
    end
endmodule

// File: doc/dht11_sensor_emulator.md
DHT11_SENSOR_EMULATOR -- requirements
Module: dht11_sensor_emulator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, on ports clock and reset.
REQ-002 Parameters SHALL be: TICKS_PER_US, default 50, clock cycles per microsecond; START_MIN_US, default 18000, minimum host start-low width.
REQ-003 Port clock, input, 1 bit: the only clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high.
REQ-005 Port enable, input, 1 bit: when 1, the emulator answers host start pulses.
REQ-006 Ports hum_int, hum_dec, temp_int, temp_dec, input, 8 bits each: payload bytes of the next frame.
REQ-007 Port force_bad_checksum, input, 1 bit: when 1, the transmitted checksum is inverted.
REQ-008 Port transmission_line, inout, 1 bit: open-drain single-wire bus; driven 0 or Z, never 1.
REQ-009 Port busy, output, 1 bit: high from start-pulse acceptance until the line is released.
REQ-010 Port frame_done, output, 1 bit: one-cycle pulse when the line is released after the final bit.
REQ-011 Port frame_count, output, 8 bits: number of completed frames, wrapping at 256.

Function
REQ-012 transmission_line SHALL be sampled through a 2-flop synchronizer; all line decisions SHALL use the synchronized value.
REQ-013 The FSM SHALL have the states IDLE, START_LOW, WAIT_RELEASE, TURNAROUND, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH and END_LOW.
REQ-014 IDLE: line released; on a synchronized falling edge with enable=1, go to START_LOW and clear the microsecond counter.
REQ-015 START_LOW: count low time in microseconds, saturating at START_MIN_US.
REQ-016 START_LOW, on a rising edge: if the count is below START_MIN_US, return to IDLE with no response; otherwise go to WAIT_RELEASE.
REQ-017 On entering WAIT_RELEASE, the block SHALL latch all four payload bytes and the checksum, and assert busy.
REQ-018 Checksum SHALL be (hum_int+hum_dec+temp_int+temp_dec) mod 256, bitwise-inverted when force_bad_checksum=1 at latch time.
REQ-019 WAIT_RELEASE/TURNAROUND: keep the line released for 30 us, then go to RESP_LOW.
REQ-020 RESP_LOW SHALL drive the line low for 80 us; RESP_HIGH SHALL then release it for 80 us.
REQ-021 Each of the 40 bits SHALL be sent as BIT_LOW (drive low 50 us), then BIT_HIGH (release 26 us for 0, 70 us for 1).
REQ-022 Bit order SHALL be MSB-first: hum_int, hum_dec, temp_int, temp_dec, checksum; a 6-bit counter selects the bit from a 40-bit shift register.
REQ-023 After bit 39, END_LOW SHALL drive the line low for 50 us, then release it and return to IDLE.
REQ-024 On that same release cycle the block SHALL pulse frame_done, clear busy and increment frame_count.
REQ-025 Payload or force_bad_checksum changes after latch SHALL NOT affect the frame in progress.
REQ-026 Line activity from outside during RESP_LOW..END_LOW SHALL be ignored (no collision detection).
REQ-027 enable falling mid-frame SHALL NOT abort the frame; enable is checked only in IDLE.
REQ-028 All durations SHALL be exact multiples of TICKS_PER_US clock cycles, timed from state entry.

Reset
REQ-029 With reset=1 at a clock edge, the block SHALL release the line on the next cycle and go to IDLE.
REQ-030 Reset values SHALL be: busy=0, frame_done=0, frame_count=0, synchronizer flops=1, counters=0; reset mid-frame discards the frame and does not increment frame_count.

Verification (TICKS_PER_US=1)
REQ-031 hum=0x37,0x00, temp=0x19,0x00, host low 18000 cycles then release -> 30 released, 80 low, 80 high, then 40 bits decoding to 0x37,0x00,0x19,0x00,0x50; END_LOW 50; frame_done once; frame_count=1.
REQ-032 Host low 17999 cycles -> line never driven, busy stays 0.
REQ-033 Payload 0xFF,0xFF,0x02,0x03 -> checksum byte 0x03; with force_bad_checksum=1, checksum byte 0xFC.
REQ-034 Reset asserted during bit 12 BIT_LOW -> line Z on the next cycle, busy=0, frame_count unchanged.
REQ-035 enable=0 with a valid 18000-cycle start -> no response; payload changed at bit 5 of an active frame -> transmitted bytes unchanged.
